demux_one_two16bit: RTL and testbench
=====================================

DEMUX_ONE_TWO16BIT -- requirements
Module: demux_one_two16bit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 2, entries per output buffer (power of two, 2..8).
REQ-003 The block SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 The block SHALL have port in_data, input, WIDTH: word offered by the upstream.
REQ-006 The block SHALL have port select, input, 1: destination; 1 routes to A, 0 routes to B.
REQ-007 The block SHALL have port in_valid, input, 1: in_data/select valid.
REQ-008 The block SHALL have port in_ready, output, 1: block accepts the word this cycle.
REQ-009 The block SHALL have ports A_data (output, WIDTH), A_valid (output, 1) and A_ready (input, 1): output stream A.
REQ-010 The block SHALL have ports B_data (output, WIDTH), B_valid (output, 1) and B_ready (input, 1): output stream B.
REQ-011 The block SHALL have ports A_count and B_count, output, 16: words delivered per channel.

Function
REQ-012 An input transfer SHALL occur when in_valid and in_ready are both high on a rising clk edge.
REQ-013 in_ready SHALL equal "buffer selected by select is not full" and SHALL NOT combinationally depend on A_ready, B_ready or in_valid.
REQ-014 An accepted word SHALL be written to FIFO A when select=1 and to FIFO B when select=0; the unselected FIFO is untouched.
REQ-015 Each FIFO SHALL hold up to DEPTH words, preserving order; occupancy 0..DEPTH.
REQ-016 X_valid SHALL be high iff FIFO X is non-empty; X_data SHALL show the head entry, registered (no flow-through), so minimum latency from input to output valid is 1 cycle.
REQ-017 An output transfer on channel X SHALL occur when X_valid and X_ready are both high; the head is popped on that edge.
REQ-018 X_data and X_valid SHALL hold stable while X_valid=1 and X_ready=0.
REQ-019 A simultaneous push and pop on the same FIFO SHALL leave occupancy unchanged; when not full, both occur.
REQ-020 When FIFO X is full, a push SHALL be refused (in_ready=0) even if a pop occurs the same cycle.
REQ-021 Pushing to FIFO B while A is full (or A while B is full) SHALL be accepted; channels SHALL be independent.
REQ-022 The FIFO read/write pointers SHALL wrap modulo DEPTH.
REQ-023 X_count SHALL increment by 1 on each channel-X output transfer and SHALL wrap from 16'hFFFF to 0.
REQ-024 select while in_valid=0 SHALL have no effect.

Reset
REQ-025 Asserting rst_n low SHALL immediately clear both FIFOs, all pointers and both counters, asynchronously to clk.
REQ-026 During reset: A_valid=0, B_valid=0, in_ready=0, A_data=0, B_data=0, A_count=0, B_count=0.
REQ-027 in_ready SHALL become 1 on the first clk edge after rst_n deasserts; words buffered before a mid-operation reset SHALL be discarded and never appear.

Structure
REQ-028 WIDTH, DEPTH defaults and the counter width (16) SHALL be constants in a shared package alu_pkg.
REQ-029 Each channel SHALL be an instance of one sub-module sync_fifo_ch (push/full, pop/empty, data, counter), instantiated twice.
REQ-030 The input side SHALL be routing logic only: steering push enables and selecting in_ready.

Verification
REQ-031 After reset, in_valid=1, select=1, in_data=16'h1234, A_ready=1 -> A_valid=1, A_data=16'h1234 one cycle later, A_count=1; B_valid stays 0.
REQ-032 A_ready=0, three words 16'h0001/0002/0003 with select=1 -> first two accepted, in_ready=0 on third until A_ready=1; A outputs 0001,0002,0003 in order.
REQ-033 A full and A_ready=0; offer 16'hBEEF with select=0, B_ready=1 -> accepted, B_data=16'hBEEF, A contents unchanged.
REQ-034 Alternate select 1/0 each cycle for 100 words, both readies high -> no stalls after first cycle; A_count=50, B_count=50, per-channel order preserved.
REQ-035 Force 65536 transfers on channel B -> B_count wraps to 0.
REQ-036 Reset asserted with both FIFOs holding data -> outputs clear immediately mid-cycle; old words never reappear after release.

Source files
------------

// File: rtl/demux_one_two16bit_pkg.sv
// Shared constants and types for the one-to-two stream demux.
// Holds default sizing, the counter width and channel encoding.
package alu_pkg;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_DEPTH = 2;
    localparam int unsigned CNT_W     = 16;

    typedef enum logic {
        CH_B = 1'b0,
        CH_A = 1'b1
    } ch_sel_e;

    function automatic logic [CNT_W-1:0] cnt_inc(
        input logic [CNT_W-1:0] i_cnt
    );
        return i_cnt + CNT_W'(1);
    endfunction

endpackage

// File: rtl/sync_fifo_ch.sv
// One output channel: small synchronous FIFO with a registered head
// and a free-running count of delivered words.
module sync_fifo_ch
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [CNT_W-1:0] o_count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_OCC = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_occ;
    logic [CNT_W-1:0] r_count;

    logic w_push_ok;
    logic w_pop;

    assign o_full    = (r_occ == FULL_OCC);
    assign o_valid   = (r_occ != '0);
    assign o_data    = r_mem[r_rd_ptr];
    assign o_count   = r_count;
    assign w_push_ok = i_push & ~o_full;
    assign w_pop     = o_valid & i_ready;

    // Storage is cleared on reset so stale words can never resurface.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
        end else if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
        end else if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ <= '0;
        end else begin
            unique case ({w_push_ok, w_pop})
                2'b10:   r_occ <= r_occ + (PTR_W + 1)'(1);
                2'b01:   r_occ <= r_occ - (PTR_W + 1)'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_pop) begin
            r_count <= cnt_inc(r_count);
        end
    end

endmodule

// File: rtl/demux_one_two16bit.sv
// One-to-two stream demux: routes each accepted word to channel A or B,
// each channel buffered by its own FIFO with a delivered-word counter.
module demux_one_two16bit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             select,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] A_data,
    output logic             A_valid,
    input  logic             A_ready,
    output logic [WIDTH-1:0] B_data,
    output logic             B_valid,
    input  logic             B_ready,
    output logic [CNT_W-1:0] A_count,
    output logic [CNT_W-1:0] B_count
);

    logic    r_en;
    ch_sel_e w_sel;
    logic    w_full_a;
    logic    w_full_b;
    logic    w_push_a;
    logic    w_push_b;
    logic    w_rdy;

    // Holds in_ready low through reset and until the first edge after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en <= 1'b0;
        end else begin
            r_en <= 1'b1;
        end
    end

    assign w_sel = ch_sel_e'(select);

    always_comb begin
        w_rdy    = 1'b0;
        w_push_a = 1'b0;
        w_push_b = 1'b0;
        unique case (w_sel)
            CH_A: begin
                w_rdy    = r_en & ~w_full_a;
                w_push_a = in_valid & w_rdy;
            end
            CH_B: begin
                w_rdy    = r_en & ~w_full_b;
                w_push_b = in_valid & w_rdy;
            end
            default: begin
                w_rdy = 1'b0;
            end
        endcase
    end

    assign in_ready = w_rdy;

    sync_fifo_ch #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ch_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push_a),
        .i_data  (in_data),
        .o_full  (w_full_a),
        .i_ready (A_ready),
        .o_valid (A_valid),
        .o_data  (A_data),
        .o_count (A_count)
    );

    sync_fifo_ch #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ch_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push_b),
        .i_data  (in_data),
        .o_full  (w_full_b),
        .i_ready (B_ready),
        .o_valid (B_valid),
        .o_data  (B_data),
        .o_count (B_count)
    );

endmodule

// File: tb/tb_demux_one_two16bit.sv
// Self-checking bench for demux_one_two16bit: directed vector table
// plus sequences for alternation, counter wrap and mid-cycle reset.
module tb_demux_one_two16bit;

    logic        clk;
    logic        rst_n;
    logic [15:0] in_data;
    logic        select;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A_data;
    logic        A_valid;
    logic        A_ready;
    logic [15:0] B_data;
    logic        B_valid;
    logic        B_ready;
    logic [15:0] A_count;
    logic [15:0] B_count;

    int n_tests;
    int n_fail;

    demux_one_two16bit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .select   (select),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A_data   (A_data),
        .A_valid  (A_valid),
        .A_ready  (A_ready),
        .B_data   (B_data),
        .B_valid  (B_valid),
        .B_ready  (B_ready),
        .A_count  (A_count),
        .B_count  (B_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic        sel;
        logic [15:0] d;
        logic        ar;
        logic        br;
        logic        e_rdy;
        logic        e_av;
        logic [15:0] e_ad;
        logic        e_bv;
        logic [15:0] e_bd;
        logic [15:0] e_ac;
        logic [15:0] e_bc;
    } vec_t;

    vec_t vec [11];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        A_ready  = 1'b0;
        B_ready  = 1'b0;
        #1;
        chk("rst_A_valid", 32'(A_valid), 32'h0);
        chk("rst_B_valid", 32'(B_valid), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_A_data", 32'(A_data), 32'h0);
        chk("rst_B_data", 32'(B_data), 32'h0);
        chk("rst_A_count", 32'(A_count), 32'h0);
        chk("rst_B_count", 32'(B_count), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rdy_before_edge", 32'(in_ready), 32'h0);
        @(posedge clk);
        #1;
        chk("rdy_after_edge", 32'(in_ready), 32'h1);
    endtask

    task automatic b_burst(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            select   = 1'b0;
            in_valid = 1'b1;
            in_data  = i[15:0];
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    logic [15:0] qa[$];
    logic [15:0] qb[$];

    task automatic mon_out();
        if (A_valid) begin
            if (qa.size() == 0) chk("alt_A_extra", 32'(A_data), 32'hFFFF_FFFF);
            else chk("alt_A_data", 32'(A_data), 32'(qa.pop_front()));
        end
        if (B_valid) begin
            if (qb.size() == 0) chk("alt_B_extra", 32'(B_data), 32'hFFFF_FFFF);
            else chk("alt_B_data", 32'(B_data), 32'(qb.pop_front()));
        end
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        in_data  = '0;
        select   = 1'b0;
        in_valid = 1'b0;
        A_ready  = 1'b0;
        B_ready  = 1'b0;

        //         v     sel   d         ar    br    rdy   av    ad        bv    bd        ac     bc
        vec[0]  = {1'b1, 1'b1, 16'h1234, 1'b1, 1'b0, 1'b1, 1'b1, 16'h1234, 1'b0, 16'h0000, 16'd0, 16'd0};
        vec[1]  = {1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'd1, 16'd0};
        vec[2]  = {1'b1, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0001, 1'b0, 16'h0000, 16'd1, 16'd0};
        vec[3]  = {1'b1, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0001, 1'b0, 16'h0000, 16'd1, 16'd0};
        vec[4]  = {1'b1, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0, 16'h0000, 16'd1, 16'd0};
        vec[5]  = {1'b1, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0, 16'h0000, 16'd1, 16'd0};
        vec[6]  = {1'b1, 1'b0, 16'hBEEF, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0001, 1'b1, 16'hBEEF, 16'd1, 16'd0};
        vec[7]  = {1'b1, 1'b1, 16'h0003, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0002, 1'b0, 16'h0000, 16'd2, 16'd1};
        vec[8]  = {1'b1, 1'b1, 16'h0003, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0003, 1'b0, 16'h0000, 16'd3, 16'd1};
        vec[9]  = {1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'd4, 16'd1};
        vec[10] = {1'b0, 1'b0, 16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'd4, 16'd1};

        do_reset();

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            in_valid = vec[i].v;
            select   = vec[i].sel;
            in_data  = vec[i].d;
            A_ready  = vec[i].ar;
            B_ready  = vec[i].br;
            #1;
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vec[i].e_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_A_valid", i), 32'(A_valid), 32'(vec[i].e_av));
            chk($sformatf("v%0d_B_valid", i), 32'(B_valid), 32'(vec[i].e_bv));
            if (vec[i].e_av)
                chk($sformatf("v%0d_A_data", i), 32'(A_data), 32'(vec[i].e_ad));
            if (vec[i].e_bv)
                chk($sformatf("v%0d_B_data", i), 32'(B_data), 32'(vec[i].e_bd));
            chk($sformatf("v%0d_A_count", i), 32'(A_count), 32'(vec[i].e_ac));
            chk($sformatf("v%0d_B_count", i), 32'(B_count), 32'(vec[i].e_bc));
        end

        // Alternating destinations with both sinks always ready.
        do_reset();
        A_ready = 1'b1;
        B_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            mon_out();
            select   = (i[0] == 1'b0);
            in_data  = 16'h0100 + i[15:0];
            in_valid = 1'b1;
            #1;
            chk("alt_in_ready", 32'(in_ready), 32'h1);
            if (in_ready) begin
                if (select) qa.push_back(in_data);
                else qb.push_back(in_data);
            end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            mon_out();
        end
        chk("alt_A_count", 32'(A_count), 32'd50);
        chk("alt_B_count", 32'(B_count), 32'd50);
        chk("alt_qa_left", 32'(qa.size()), 32'd0);
        chk("alt_qb_left", 32'(qb.size()), 32'd0);

        // Channel B counter wrap.
        do_reset();
        B_ready = 1'b1;
        A_ready = 1'b1;
        b_burst(65535);
        chk("wrap_B_count_max", 32'(B_count), 32'h0000_FFFF);
        b_burst(1);
        chk("wrap_B_count_zero", 32'(B_count), 32'h0);
        chk("wrap_B_valid", 32'(B_valid), 32'h0);
        chk("wrap_A_count", 32'(A_count), 32'h0);

        // Mid-cycle reset with both FIFOs holding data.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            select   = (i < 2);
            in_data  = (i < 2) ? 16'hAAA1 + i[15:0] : 16'hBBB1 + i[15:0];
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("mr_A_valid_pre", 32'(A_valid), 32'h1);
        chk("mr_B_valid_pre", 32'(B_valid), 32'h1);
        chk("mr_A_data_pre", 32'(A_data), 32'hAAA1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_A_valid", 32'(A_valid), 32'h0);
        chk("mr_B_valid", 32'(B_valid), 32'h0);
        chk("mr_in_ready", 32'(in_ready), 32'h0);
        chk("mr_A_data", 32'(A_data), 32'h0);
        chk("mr_B_data", 32'(B_data), 32'h0);
        @(negedge clk);
        rst_n   = 1'b1;
        A_ready = 1'b1;
        B_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("mr_rdy_after", 32'(in_ready), 32'h1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mr_no_old_A", 32'(A_valid), 32'h0);
            chk("mr_no_old_B", 32'(B_valid), 32'h0);
        end
        @(negedge clk);
        A_ready  = 1'b0;
        select   = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h5555;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("mr_new_A_valid", 32'(A_valid), 32'h1);
        chk("mr_new_A_data", 32'(A_data), 32'h5555);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
